// File: rtl/kv_mem_pkg.sv
// Shared types and defaults for the two-requester line-fetch arbiter.
package kv_mem_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 32;
   localparam int LINE_SIZE_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam logic REQ_IFETCH = 1'b0;
   localparam logic REQ_DLOAD  = 1'b1;

endpackage

// File: rtl/kv_arb2_sel.sv
// Two-way grant selector. KV_MEM_ARB_RR_EN selects round-robin on ties;
// otherwise the data-load requester always wins a tie.
module kv_arb2_sel
   import kv_mem_pkg::*;
(
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic       grant_o,
   output logic       any_o
);

   assign any_o = |valid_i;

`ifdef KV_MEM_ARB_RR_EN
   always_comb begin
      if (valid_i == 2'b11) grant_o = ~last_grant_i;
      else                  grant_o = valid_i[1];
   end
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant_i;

   always_comb begin
      grant_o = valid_i[1] ? REQ_DLOAD : REQ_IFETCH;
   end
`endif

endmodule

// File: rtl/kv_mem_arbiter.sv
// Arbitrates instruction-fetch and data-load line reads onto one memory port,
// one transaction at a time. Define KV_MEM_ARB_RR_EN for round-robin ties.
module kv_mem_arbiter
   import kv_mem_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int LINE_SIZE  = LINE_SIZE_DEF
) (
   input  logic                                i_clk,
   input  logic                                i_rstn,
   input  logic [1:0][ADDR_WIDTH-1:0]          i_req_addr,
   input  logic [1:0]                          i_req_valid,
   output logic [1:0]                          o_req_ready,
   output logic [LINE_SIZE*DATA_WIDTH-1:0]     o_rsp_data,
   output logic [1:0]                          o_rsp_valid,
   input  logic [1:0]                          i_rsp_ready,
   output logic [ADDR_WIDTH-1:0]               o_mem_read_addr,
   output logic                                o_mem_read_valid,
   input  logic                                i_mem_read_ready,
   input  logic [LINE_SIZE*DATA_WIDTH-1:0]     i_mem_read_data,
   input  logic                                i_mem_read_valid,
   output logic                                o_mem_read_ready,
   output arb_state_t                          o_dbg_state
);

   // Handshakes: a transfer occurs on a rising edge where valid and ready are
   // both 1; a valid, once raised, holds with stable payload until that edge.

   arb_state_t state_q, state_d;
   logic       grant_q;
   logic       grant;
   logic       any_req;
   logic       last_grant;

`ifdef KV_MEM_ARB_RR_EN
   logic last_grant_q;
   assign last_grant = last_grant_q;
`else
   assign last_grant = 1'b1;
`endif

   kv_arb2_sel u_sel (
      .valid_i      (i_req_valid),
      .last_grant_i (last_grant),
      .grant_o      (grant),
      .any_o        (any_req)
   );

   // Everything facing the memory or requesters is zero unless the state
   // owns that channel, so an asynchronous reset silences all outputs at once.
   always_comb begin
      state_d          = state_q;
      o_req_ready      = 2'b00;
      o_rsp_valid      = 2'b00;
      o_rsp_data       = '0;
      o_mem_read_addr  = '0;
      o_mem_read_valid = 1'b0;
      o_mem_read_ready = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) state_d = ADDR;
         end
         ADDR: begin
            o_mem_read_valid     = 1'b1;
            o_mem_read_addr      = i_req_addr[grant_q];
            o_req_ready[grant_q] = i_mem_read_ready;
            if (i_mem_read_ready) state_d = RESP;
         end
         RESP: begin
            o_rsp_valid[grant_q] = i_mem_read_valid;
            o_rsp_data           = i_mem_read_data;
            o_mem_read_ready     = i_rsp_ready[grant_q];
            if (i_mem_read_valid && i_rsp_ready[grant_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q      <= IDLE;
         grant_q      <= REQ_IFETCH;
`ifdef KV_MEM_ARB_RR_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && any_req) begin
            grant_q      <= grant;
`ifdef KV_MEM_ARB_RR_EN
            last_grant_q <= grant;
`endif
         end
      end
   end

   assign o_dbg_state = state_q;

`ifndef SYNTHESIS
   a_req0_hold : assert property (@(posedge i_clk) disable iff (!i_rstn)
      (i_req_valid[0] && !o_req_ready[0]) |=> i_req_valid[0])
      else $error("requester 0 dropped i_req_valid before o_req_ready");
   a_req1_hold : assert property (@(posedge i_clk) disable iff (!i_rstn)
      (i_req_valid[1] && !o_req_ready[1]) |=> i_req_valid[1])
      else $error("requester 1 dropped i_req_valid before o_req_ready");
`endif

endmodule

// File: tb/tb_kv_mem_arbiter.sv
// Directed bench for kv_mem_arbiter; expectations follow KV_MEM_ARB_RR_EN.
module tb_kv_mem_arbiter;
   import kv_mem_pkg::*;

`ifdef KV_MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   localparam logic [127:0] LINE_0 = {32'h5555_5555, 32'h5555_0000, 32'h0000_5555, 32'h0000_0000};
   localparam logic [127:0] LINE_4 = {32'h8888_8888, 32'h0000_9999, 32'h9999_0000, 32'h9999_9999};

   logic               i_clk = 1'b0;
   logic               i_rstn = 1'b0;
   logic [1:0][31:0]   i_req_addr = '0;
   logic [1:0]         i_req_valid = 2'b00;
   logic [1:0]         o_req_ready;
   logic [127:0]       o_rsp_data;
   logic [1:0]         o_rsp_valid;
   logic [1:0]         i_rsp_ready = 2'b00;
   logic [31:0]        o_mem_read_addr;
   logic               o_mem_read_valid;
   logic               i_mem_read_ready = 1'b0;
   logic [127:0]       i_mem_read_data = '0;
   logic               i_mem_read_valid = 1'b0;
   logic               o_mem_read_ready;
   arb_state_t         o_dbg_state;

   int checks = 0;
   int failures = 0;
   int mem_txn_cnt = 0;
   logic model_last = 1'b1;

   kv_mem_arbiter dut (
      .i_clk            (i_clk),
      .i_rstn           (i_rstn),
      .i_req_addr       (i_req_addr),
      .i_req_valid      (i_req_valid),
      .o_req_ready      (o_req_ready),
      .o_rsp_data       (o_rsp_data),
      .o_rsp_valid      (o_rsp_valid),
      .i_rsp_ready      (i_rsp_ready),
      .o_mem_read_addr  (o_mem_read_addr),
      .o_mem_read_valid (o_mem_read_valid),
      .i_mem_read_ready (i_mem_read_ready),
      .i_mem_read_data  (i_mem_read_data),
      .i_mem_read_valid (i_mem_read_valid),
      .o_mem_read_ready (o_mem_read_ready),
      .o_dbg_state      (o_dbg_state)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [127:0] mem_line(input logic [31:0] a);
      case (a)
         32'h0:   mem_line = LINE_0;
         32'h4:   mem_line = LINE_4;
         default: mem_line = {a ^ 32'hA5A5_A5A5, a, ~a, a + 32'h1111_0000};
      endcase
   endfunction

   // Reference arbitration: which requester should win for a given valid set.
   function automatic int model_grant(input logic [1:0] v);
      if (v == 2'b11) model_grant = RR ? (model_last ? 0 : 1) : 1;
      else            model_grant = v[1] ? 1 : 0;
   endfunction

   // Entered at a negedge with the state IDLE and i_req_valid already driven.
   task automatic do_txn(input string name, input int addr_stall, input int rsp_stall,
                         input bit keep_valid);
      int          g;
      logic [1:0]  gmask;
      logic [31:0] exp_addr;
      logic [127:0] exp_line;
      g = model_grant(i_req_valid);
      model_last = g[0];
      gmask = 2'b01 << g;
      exp_addr = i_req_addr[g];
      exp_line = mem_line(exp_addr);
      i_mem_read_ready = 1'b0;
      i_mem_read_valid = 1'b0;
      i_rsp_ready = 2'b00;
      #1;
      check_eq({name, "_idle_state"}, o_dbg_state, IDLE);
      check_eq({name, "_idle_memv"}, o_mem_read_valid, 1'b0);
      @(negedge i_clk); #1;
      check_eq({name, "_addr_state"}, o_dbg_state, ADDR);
      check_eq({name, "_memv"}, o_mem_read_valid, 1'b1);
      check_eq({name, "_mem_addr"}, o_mem_read_addr, exp_addr);
      for (int c = 0; c < addr_stall; c++) begin
         check_eq({name, "_stall_req_ready"}, o_req_ready, 2'b00);
         @(negedge i_clk); #1;
         check_eq({name, "_stall_memv"}, o_mem_read_valid, 1'b1);
         check_eq({name, "_stall_addr"}, o_mem_read_addr, exp_addr);
      end
      i_mem_read_ready = 1'b1;
      #1;
      check_eq({name, "_req_ready"}, o_req_ready, gmask);
      if (o_mem_read_valid) mem_txn_cnt++;
      @(negedge i_clk);
      i_mem_read_ready = 1'b0;
      if (!keep_valid) i_req_valid[g] = 1'b0;
      #1;
      check_eq({name, "_resp_state"}, o_dbg_state, RESP);
      check_eq({name, "_resp_memv"}, o_mem_read_valid, 1'b0);
      check_eq({name, "_resp_early_rspv"}, o_rsp_valid, 2'b00);
      i_mem_read_valid = 1'b1;
      i_mem_read_data = exp_line;
      for (int c = 0; c < rsp_stall; c++) begin
         #1;
         check_eq({name, "_bp_rspv"}, o_rsp_valid, gmask);
         check_eq({name, "_bp_mem_ready"}, o_mem_read_ready, 1'b0);
         check_eq({name, "_bp_state"}, o_dbg_state, RESP);
         @(negedge i_clk);
      end
      i_rsp_ready = 2'b11;
      #1;
      check_eq({name, "_rspv"}, o_rsp_valid, gmask);
      check_eq({name, "_rsp_data"}, o_rsp_data, exp_line);
      check_eq({name, "_mem_ready"}, o_mem_read_ready, 1'b1);
      @(negedge i_clk);
      i_mem_read_valid = 1'b0;
      i_mem_read_data = '0;
      i_rsp_ready = 2'b00;
      #1;
      check_eq({name, "_post_state"}, o_dbg_state, IDLE);
      check_eq({name, "_post_memv"}, o_mem_read_valid, 1'b0);
   endtask

   task automatic check_quiet(input string name);
      check_eq({name, "_state"}, o_dbg_state, IDLE);
      check_eq({name, "_req_ready"}, o_req_ready, 2'b00);
      check_eq({name, "_rspv"}, o_rsp_valid, 2'b00);
      check_eq({name, "_memv"}, o_mem_read_valid, 1'b0);
      check_eq({name, "_mem_ready"}, o_mem_read_ready, 1'b0);
   endtask

   initial begin
      int base;
      // Reset state
      repeat (2) @(negedge i_clk);
      #1;
      check_quiet("reset");
      @(negedge i_clk);
      i_rstn = 1'b1;
      model_last = 1'b1;

      // Simultaneous requests: exactly two memory transactions
      @(negedge i_clk);
      base = mem_txn_cnt;
      i_req_addr[0] = 32'h0;
      i_req_addr[1] = 32'h4;
      i_req_valid = 2'b11;
      do_txn("tie_a", 0, 0, 1'b0);
      do_txn("tie_b", 0, 0, 1'b0);
      check_eq("tie_mem_txns", 128'(mem_txn_cnt - base), 128'd2);

      // Single instruction fetch from 0x0
      @(negedge i_clk);
      i_req_addr[0] = 32'h0;
      i_req_valid = 2'b01;
      do_txn("single", 0, 0, 1'b0);

      // Response backpressure for 5 cycles
      @(negedge i_clk);
      i_req_addr[1] = 32'h8;
      i_req_valid = 2'b10;
      do_txn("rsp_bp", 0, 5, 1'b0);

      // Memory address stall for 3 cycles
      @(negedge i_clk);
      i_req_addr[0] = 32'hC;
      i_req_valid = 2'b01;
      do_txn("addr_stall", 3, 0, 1'b0);

      // Reset while in RESP with the response already valid
      @(negedge i_clk);
      i_req_addr[1] = 32'h8;
      i_req_valid = 2'b10;
      @(negedge i_clk);
      i_mem_read_ready = 1'b1;
      @(negedge i_clk);
      i_mem_read_ready = 1'b0;
      i_req_valid = 2'b00;
      i_mem_read_valid = 1'b1;
      i_mem_read_data = mem_line(32'h8);
      #1;
      check_eq("rst_pre_state", o_dbg_state, RESP);
      check_eq("rst_pre_rspv", o_rsp_valid, 2'b10);
      #1;
      i_rstn = 1'b0;
      #1;
      check_quiet("rst_mid");
      check_eq("rst_mid_data", o_rsp_data, 128'd0);
      i_mem_read_valid = 1'b0;
      i_mem_read_data = '0;
      repeat (2) @(negedge i_clk);
      i_rstn = 1'b1;
      model_last = 1'b1;
      @(negedge i_clk);
      i_req_addr[0] = 32'h4;
      i_req_valid = 2'b01;
      do_txn("after_rst", 0, 0, 1'b0);

      // Continuous requests from both sides for 8 transactions
      @(negedge i_clk);
      i_req_addr[0] = 32'h20;
      i_req_addr[1] = 32'h24;
      i_req_valid = 2'b11;
      for (int t = 0; t < 8; t++) begin
         int prev;
         prev = model_last;
         do_txn($sformatf("cont%0d", t), t % 2, 0, 1'b1);
         if (RR && t > 0) check_eq("cont_alternates", 128'(model_last), 128'(!prev));
      end
      i_rstn = 1'b0;
      @(negedge i_clk);
      i_req_valid = 2'b00;
      #1;
      check_quiet("final_rst");
      @(negedge i_clk);
      i_rstn = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/kv_mem_arbiter.md
KV_MEM_ARBITER -- requirements
Module: kv_mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-003 The block SHALL have parameter LINE_SIZE, default 4, meaning words per returned line.
REQ-004 The block SHALL have port i_clk, input, 1, the single clock.
REQ-005 The block SHALL have port i_rstn, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port i_req_addr[1:0], input, 2xADDR_WIDTH, the per-requester read address (0 = instruction fetch, 1 = data load).
REQ-007 The block SHALL have ports i_req_valid[1:0] (input, 2) and o_req_ready[1:0] (output, 2), the per-requester address handshake.
REQ-008 The block SHALL have port o_rsp_data, output, LINE_SIZExDATA_WIDTH, the returned line, broadcast to both requesters.
REQ-009 The block SHALL have ports o_rsp_valid[1:0] (output, 2) and i_rsp_ready[1:0] (input, 2), the per-requester response handshake.
REQ-010 The block SHALL have ports o_mem_read_addr (output, ADDR_WIDTH), o_mem_read_valid (output, 1) and i_mem_read_ready (input, 1), the memory address channel.
REQ-011 The block SHALL have ports i_mem_read_data (input, LINE_SIZExDATA_WIDTH), i_mem_read_valid (input, 1) and o_mem_read_ready (output, 1), the memory data channel.

Function
REQ-012 The block SHALL use FSM states IDLE, ADDR and RESP, with at most one transaction outstanding.
REQ-013 IDLE: if any i_req_valid is set, the block SHALL register grant g per REQ-026 and go to ADDR on the next edge; otherwise it SHALL stay in IDLE.
REQ-014 ADDR: o_mem_read_valid SHALL be 1 and o_mem_read_addr SHALL equal i_req_addr[g] (combinational mux).
REQ-015 ADDR: o_req_ready[g] SHALL equal i_mem_read_ready, and the block SHALL go to RESP on the edge where i_mem_read_ready=1.
REQ-016 RESP: o_rsp_valid[g] SHALL equal i_mem_read_valid, o_rsp_data SHALL equal i_mem_read_data, and o_mem_read_ready SHALL equal i_rsp_ready[g].
REQ-017 RESP: on the edge where i_mem_read_valid and i_rsp_ready[g] are both 1, the block SHALL return to IDLE.
REQ-018 The non-granted requester SHALL see o_req_ready=0 and o_rsp_valid=0 at all times.
REQ-019 Outside ADDR, o_mem_read_valid SHALL be 0; outside RESP, o_mem_read_ready SHALL be 0 and i_mem_read_valid SHALL be ignored.
REQ-020 Minimum latency SHALL be: valid seen in IDLE at cycle N, memory address valid at N+1.
REQ-021 After a response handshake the block SHALL spend one IDLE cycle before the next grant (no back-to-back re-grant).
REQ-022 A requester dropping i_req_valid before its ready SHALL be a protocol violation and SHALL be flagged by a simulation assertion.
REQ-023 A requester stalling i_rsp_ready=0 SHALL hold the FSM in RESP indefinitely, with o_rsp_data tracking the memory's held data.

Reset
REQ-024 When i_rstn=0, the block SHALL asynchronously set state=IDLE and last_grant=1, and force all valid/ready outputs to 0.
REQ-025 Reset mid-transaction SHALL drop the transaction with no response, and the memory SHALL share i_rstn so that its pipeline is also flushed.

Configuration
REQ-026 With macro KV_MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on a tie, grant !last_grant; last_grant updates on each grant; the first tie after reset goes to requester 0.
REQ-027 Without KV_MEM_ARB_RR_EN, arbitration SHALL be fixed priority with requester 1 (data) winning ties, and last_grant SHALL be unused.

Structure
REQ-028 Package kv_mem_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH/LINE_SIZE defaults, the arb_state_t enum (IDLE, ADDR, RESP) and the requester-id constants REQ_IFETCH=0 and REQ_DLOAD=1.
REQ-029 Grant selection SHALL be a sub-module kv_arb2_sel (combinational: valid[1:0], last_grant -> grant, any).

Verification
REQ-030 Single request: i_req_valid=01, addr 0x0 -> one mem request with addr 0x0; requester 0 receives line {0x5555_5555, 0x5555_0000, 0x0000_5555, 0x0000_0000}; o_rsp_valid[1] stays 0.
REQ-031 Simultaneous requests: valid=11, addrs 0x0/0x4 -> with RR: grants 0 then 1; without RR: grants 1 then 0; exactly two memory transactions.
REQ-032 Response backpressure: i_rsp_ready[g]=0 for 5 cycles -> o_mem_read_ready=0 and FSM stays in RESP; completes the cycle ready rises.
REQ-033 Memory address stall: i_mem_read_ready=0 for 3 cycles -> o_mem_read_valid stays 1 with a stable address and o_req_ready stays 0.
REQ-034 Reset mid-RESP: i_rstn=0 asynchronously -> all outputs 0 immediately; after release, a new request to 0x4 returns {0x8888_8888, 0x0000_9999, 0x9999_0000, 0x9999_9999}.
REQ-035 Continuous valid=11 for 8 transactions with RR -> grant sequence alternates 0,1,0,1,... with no starvation.
